// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package add_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index counter width; a single-nibble build still needs one bit.
  function automatic int idx_width(input int n_nib);
    return (n_nib > 1) ? $clog2(n_nib) : 1;
  endfunction

endpackage

// File: rtl/fa4_mbit.sv
// 4-bit ripple full adder used as the single arithmetic slice of add16_seq.
module fa4_mbit
  import add_seq_pkg::*;
(
  output logic [NIB_W-1:0] s,
  output logic             co,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci
);

  logic [NIB_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
  assign s   = sum[NIB_W-1:0];
  assign co  = sum[NIB_W];

endmodule

// File: rtl/add16_seq.sv
// Nibble-serial add/subtract: one 4-bit adder slice processes one nibble per
// cycle, with valid/ready handshakes on both the request and result sides.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// ADD   | one nibble per cycle through fa4_mbit
// DONE  | result held, out_valid=1 until out_ready
module add16_seq
  import add_seq_pkg::*;
#(
  parameter int N_NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [NIB_W*N_NIB-1:0] a,
  input  logic [NIB_W*N_NIB-1:0] b,
  input  logic                   ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] s,
  output logic                   co
);

  localparam int W     = NIB_W * N_NIB;
  localparam int IDX_W = idx_width(N_NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NIB - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_reg_q, a_reg_d;
  logic [W-1:0]     b_reg_q, b_reg_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     s_q, s_d;
  logic             co_q, co_d;

  logic [NIB_W-1:0] fa_a, fa_b, fa_s;
  logic             fa_co;
  int               nib_lsb;

  always_comb begin
    nib_lsb = int'(idx_q) * NIB_W;
    fa_a    = a_reg_q[nib_lsb +: NIB_W];
    fa_b    = b_reg_q[nib_lsb +: NIB_W];
  end

  fa4_mbit u_fa (
    .s  (fa_s),
    .co (fa_co),
    .a  (fa_a),
    .b  (fa_b),
    .ci (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    co_d    = co_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + 1, so the carry chain starts at 1.
          a_reg_d = a;
          b_reg_d = op ? ~b : b;
          carry_d = op ? 1'b1 : ci;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        s_d[nib_lsb +: NIB_W] = fa_s;
        carry_d = fa_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          co_d    = fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_reg_q <= '0;
      b_reg_q <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign co        = co_q;

endmodule
